// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, reads the combinational program ROM and
// queues {pc, instruction} pairs for decode behind a valid/ready handshake.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] Pc_Addr_o,
    input  logic [DATA_WIDTH-1:0] Mem_Instruction_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Redirect_Target_i,
    output logic                  Instr_Valid_o,
    input  logic                  Instr_Ready_i,
    output logic [DATA_WIDTH-1:0] Instr_o,
    output logic [DATA_WIDTH-1:0] Instr_Pc_o,
    output logic                  Misaligned_o,
    output logic [DATA_WIDTH-1:0] Fetch_Count_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PTR_W-1:0]      PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(3'd4);
    localparam logic [DATA_WIDTH-1:0] ONE_W    = DATA_WIDTH'(1'b1);
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_n_s;
    logic [DATA_WIDTH-1:0]   fetch_pc_r;
    logic [DATA_WIDTH-1:0]   fetch_pc_n_s;
    logic [DATA_WIDTH-1:0]   fifo_instr_r [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_pc_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        wr_ptr_n_s;
    logic [PTR_W-1:0]        rd_ptr_n_s;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_n_s;
    logic                    deq_s;
    logic                    enq_s;
    logic                    redirect_s;
    logic                    misaligned_s;
    logic [DATA_WIDTH-1:0]   head_instr_n_s;
    logic [DATA_WIDTH-1:0]   head_pc_n_s;

    assign Pc_Addr_o = fetch_pc_r;

    // Handshake, redirect qualification and enqueue enable
    always_comb begin
        deq_s        = Instr_Valid_o & Instr_Ready_i;
        redirect_s   = Redirect_i & (state_r != ST_HALT);
        misaligned_s = redirect_s & (Redirect_Target_i[1:0] != 2'b00);
        // A full queue can still accept when decode drains the head this cycle.
        enq_s        = (state_r == ST_RUN) & ~Redirect_i & ((count_r < DEPTH_C) | deq_s);
    end

    // Next-state for FSM, PC and queue pointers
    always_comb begin
        state_n_s    = state_r;
        fetch_pc_n_s = fetch_pc_r;
        wr_ptr_n_s   = wr_ptr_r;
        rd_ptr_n_s   = rd_ptr_r;
        count_n_s    = count_r;
        if (redirect_s) begin
            wr_ptr_n_s = PTR_ZERO;
            rd_ptr_n_s = PTR_ZERO;
            count_n_s  = CNT_ZERO;
            if (misaligned_s) begin
                state_n_s = ST_HALT;
            end else begin
                state_n_s    = ST_RUN;
                fetch_pc_n_s = Redirect_Target_i;
            end
        end else begin
            case (state_r)
                ST_IDLE: state_n_s = ST_RUN;
                ST_RUN:  state_n_s = ST_RUN;
                ST_HALT: state_n_s = ST_HALT;
                default: state_n_s = ST_IDLE;
            endcase
            if (enq_s) begin
                wr_ptr_n_s   = wr_ptr_r + PTR_ONE;
                fetch_pc_n_s = fetch_pc_r + PC_STEP;
            end else begin
                wr_ptr_n_s   = wr_ptr_r;
            end
            if (deq_s) begin
                rd_ptr_n_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_n_s = rd_ptr_r;
            end
            case ({enq_s, deq_s})
                2'b10:   count_n_s = count_r + CNT_ONE;
                2'b01:   count_n_s = count_r - CNT_ONE;
                default: count_n_s = count_r;
            endcase
        end
    end

    // Next head entry; bypasses the word being written when it becomes the head
    always_comb begin
        head_instr_n_s = ZERO_W;
        head_pc_n_s    = ZERO_W;
        if (count_n_s == CNT_ZERO) begin
            head_instr_n_s = ZERO_W;
            head_pc_n_s    = ZERO_W;
        end else if (enq_s && (rd_ptr_n_s == wr_ptr_r)) begin
            head_instr_n_s = Mem_Instruction_i;
            head_pc_n_s    = fetch_pc_r;
        end else begin
            head_instr_n_s = fifo_instr_r[rd_ptr_n_s];
            head_pc_n_s    = fifo_pc_r[rd_ptr_n_s];
        end
    end

    // Queue storage, written only on enqueue
    always_ff @(posedge clk) begin
        if (enq_s && !reset) begin
            fifo_instr_r[wr_ptr_r] <= Mem_Instruction_i;
            fifo_pc_r[wr_ptr_r]    <= fetch_pc_r;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= RESET_PC;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            Instr_Valid_o <= 1'b0;
            Instr_o       <= ZERO_W;
            Instr_Pc_o    <= ZERO_W;
            Misaligned_o  <= 1'b0;
            Fetch_Count_o <= ZERO_W;
        end else begin
            state_r       <= state_n_s;
            fetch_pc_r    <= fetch_pc_n_s;
            wr_ptr_r      <= wr_ptr_n_s;
            rd_ptr_r      <= rd_ptr_n_s;
            count_r       <= count_n_s;
            Instr_Valid_o <= (count_n_s != CNT_ZERO);
            Instr_o       <= head_instr_n_s;
            Instr_Pc_o    <= head_pc_n_s;
            Misaligned_o  <= Misaligned_o | misaligned_s;
            if (enq_s) begin
                Fetch_Count_o <= Fetch_Count_o + ONE_W;
            end
        end
    end

endmodule
